motor_cmd_tx: RTL and testbench
===============================

Name: motor_cmd_tx

Overview:
- Remote-side command encoder and UART transmitter, the far end of the car's command receive path.
- Samples five push-buttons and packs them into the car's 8-bit command byte: {motor[2:0], servo[2:0], 2'b00}.
- Serialises each byte as UART 8N1 at BAUD_RATE.
- Sits on the remote/test board and drives the car's rx_pin directly.

Parameters:
- SYS_CLK_FREQ, 100_000_000, sys_clk frequency in Hz.
- BAUD_RATE, 115200, UART bit rate.
- CLKS_PER_BIT, SYS_CLK_FREQ/BAUD_RATE (868), sys_clk cycles per UART bit (integer division).
- PERIOD_CYC, 2_000_000, cycles between periodic command frames (20 ms).

Ports:
- sys_clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- btn_fwd  input  1  forward button, async level, active-high
- btn_back  input  1  backward button
- btn_left  input  1  steer-left button
- btn_right  input  1  steer-right button
- btn_center  input  1  steer-straight button
- tx_pin  output  1  UART serial out, idle high
- busy  output  1  high while a frame is on the line
- sent  output  1  one-cycle pulse when a stop bit completes
- sent_byte  output  8  last byte transmitted; valid from the sent pulse onward

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: tx_pin=1, busy=0, sent=0, sent_byte=8'h00. Period counter=0, pending=0, last_motor=3'b000. FSM in IDLE.
- A reset mid-frame aborts the frame: tx_pin goes high asynchronously.
- Input sync: each button passes through a 2-flop synchroniser. There is no debounce, because the periodic sampling absorbs bounce.
- Motor code (combinational from synced buttons):
  - fwd & ~back -> 3'b011
  - back & ~fwd -> 3'b110
  - otherwise (none or both pressed) -> 3'b000 (halt)
- Servo code:
  - center -> 3'b101, with priority over left/right
  - else left & ~right -> 3'b011
  - else right & ~left -> 3'b110
  - else 3'b000 (no change)
- Command byte = {motor, servo, 2'b00}. Bits [1:0] are always 0.
- Request sources:
  - The period counter counts 0..PERIOD_CYC-1. At wrap it sets pending.
  - The synced motor code differing from last_motor also sets pending.
  - Multiple requests before service merge into a single pending.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: if pending, clear pending, latch the current command byte into shift_reg, set last_motor to its motor field, and go to START next cycle. busy rises the same cycle as the transition.
  - START: tx_pin=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit index runs 0..7.
  - STOP: tx_pin=1 for CLKS_PER_BIT cycles. At the end, sent pulses for 1 cycle, sent_byte is loaded with the transmitted byte, busy falls, and the FSM returns to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles (8680 at defaults).
- Latency from pending set (with FSM IDLE) to the start-bit falling edge is 1 cycle.
- The byte is sampled at load time, not at request time. A button change during a frame is reflected in the next frame.
- A pending set during a frame is served in the first IDLE cycle after STOP, so two frames can be back-to-back with one IDLE cycle between them.
- When a tick and a motor change occur in the same cycle, one pending results and one frame is sent.
- The bit counter is sized for CLKS_PER_BIT-1 and the period counter for PERIOD_CYC-1. Neither counter ever exceeds its maximum.

Decomposition:
- Package motor_cmd_pkg holds:
  - MOTOR_FWD=3'b011, MOTOR_BACK=3'b110, MOTOR_HALT=3'b000
  - SERVO_LEFT=3'b011, SERVO_RIGHT=3'b110, SERVO_STRAIGHT=3'b101, SERVO_NONE=3'b000
  - the UART state encoding
  - a function that packs {motor, servo, 2'b00}
- One sub-module, uart_tx_core: an 8N1 serialiser with a start/byte-in/busy/done handshake, parameterised by CLKS_PER_BIT.
- The top level keeps the synchronisers, encoding, period counter and pending logic.

Test Plan:
- Reset release, no buttons held:
  - first frame starts at cycle PERIOD_CYC (+1 load cycle) and carries byte 8'h00
  - tx_pin stays high before that frame
  - the 0x00 frame reads LSB-first: start 0, eight 0s, stop 1, each bit 868 cycles wide
- Press btn_fwd at idle: within 4 cycles (2 sync + 1 detect + 1 load) the start bit begins; sent_byte=8'h60, sent pulses after 8680 cycles.
- Hold btn_left with fwd over 3 periods: three frames of 8'h6C, one per 2_000_000 cycles; no extra frames.
- btn_fwd and btn_back together: byte 8'h00. Add btn_center with left and right held: servo field 101, byte 8'h14.
- Press btn_back mid-frame of an 8'h60 frame: current frame completes unchanged. The next frame starts 1 cycle after STOP ends with 8'hC0 and only one extra frame is sent.
- Assert rst during DATA bit 3: tx_pin=1 and busy=0 immediately. After release no frame is sent until the next period wrap, with buttons released.

Source files
------------

// File: rtl/motor_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_cmd_pkg
//  Description : Shared constants for the remote-side motor command encoder:
//                motor/servo field codes, UART transmitter state encoding and
//                the command-byte packing helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package motor_cmd_pkg;

    // Motor field codes (command byte bits [7:5])
    localparam logic [2:0] MOTOR_FWD      = 3'b011;
    localparam logic [2:0] MOTOR_BACK     = 3'b110;
    localparam logic [2:0] MOTOR_HALT     = 3'b000;

    // Servo field codes (command byte bits [4:2])
    localparam logic [2:0] SERVO_LEFT     = 3'b011;
    localparam logic [2:0] SERVO_RIGHT    = 3'b110;
    localparam logic [2:0] SERVO_STRAIGHT = 3'b101;
    localparam logic [2:0] SERVO_NONE     = 3'b000;

    // UART transmitter state encoding
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_START       = 2'd1;
    localparam logic [1:0] ST_DATA        = 2'd2;
    localparam logic [1:0] ST_STOP        = 2'd3;

    // Command byte layout: {motor, servo, 2'b00}; the two LSBs are reserved.
    function automatic logic [7:0] pack_cmd(input logic [2:0] motor,
                                            input logic [2:0] servo);
        return {motor, servo, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_core
//  Description : 8N1 UART serialiser. A one-cycle i_start while idle latches
//                i_data and sends start bit, 8 data bits LSB first and a stop
//                bit, each CLKS_PER_BIT cycles wide.
//  Ports       : clk, rst (async, active-high)
//                i_start     - load request, honoured only while idle
//                i_data      - byte to send, sampled on the accepted i_start
//                o_tx        - serial line, idle high
//                o_busy      - high from the accepting cycle until the stop
//                              bit ends
//                o_done      - one-cycle pulse as the stop bit completes
//                o_sent_byte - last completed byte, updated with o_done
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import motor_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_sent_byte
);

    localparam int              c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state,     w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [2:0]         r_idx,       w_idx_nxt;
    logic [7:0]         r_data,      w_data_nxt;
    logic               r_tx,        w_tx_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_done,      w_done_nxt;
    logic [7:0]         r_sent_byte, w_sent_byte_nxt;
    logic               w_bit_end;

    always_comb begin
        w_bit_end       = (r_cnt == c_BIT_MAX);
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_data_nxt      = r_data;
        w_tx_nxt        = r_tx;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_sent_byte_nxt = r_sent_byte;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = i_data;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_data[r_idx + 3'd1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt     = ST_IDLE;
                    w_cnt_nxt       = '0;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_sent_byte_nxt = r_data;
                end else begin
                    w_cnt_nxt       = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Async reset forces the line idle at once, aborting any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_data      <= 8'h00;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sent_byte <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_data      <= w_data_nxt;
            r_tx        <= w_tx_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_sent_byte <= w_sent_byte_nxt;
        end
    end

    assign o_tx        = r_tx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_sent_byte = r_sent_byte;

endmodule
`default_nettype wire

// File: rtl/motor_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : motor_cmd_tx
//  Description : Remote-side command encoder. Synchronises five buttons,
//                encodes them into {motor, servo, 2'b00} and sends the byte
//                as UART 8N1 every PERIOD_CYC cycles and whenever the motor
//                code changes.
//  Ports       : sys_clk, rst (async, active-high)
//                btn_fwd/btn_back/btn_left/btn_right/btn_center - async buttons
//                tx_pin    - UART serial out, idle high
//                busy      - high while a frame is on the line
//                sent      - one-cycle pulse when a stop bit completes
//                sent_byte - last byte transmitted
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_cmd_tx
    import motor_cmd_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE,
    parameter int PERIOD_CYC   = 2_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       btn_fwd,
    input  logic       btn_back,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic       tx_pin,
    output logic       busy,
    output logic       sent,
    output logic [7:0] sent_byte
);

    localparam int                 c_PER_W   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [c_PER_W-1:0] c_PER_MAX = c_PER_W'(PERIOD_CYC - 1);
    localparam logic [c_PER_W-1:0] c_PER_ONE = c_PER_W'(1);

    // Button vector order: [0]=fwd [1]=back [2]=left [3]=right [4]=center
    logic [4:0]         w_btn_raw;
    logic [4:0]         r_btn_meta;
    logic [4:0]         r_btn_sync;
    logic [c_PER_W-1:0] r_period_cnt, w_period_cnt_nxt;
    logic               r_pending,    w_pending_nxt;
    logic [2:0]         r_last_motor, w_last_motor_nxt;
    logic [2:0]         w_motor;
    logic [2:0]         w_servo;
    logic [7:0]         w_cmd;
    logic               w_tick;
    logic               w_load;
    logic               w_busy;

    assign w_btn_raw = {btn_center, btn_right, btn_left, btn_back, btn_fwd};

    always_comb begin
        w_motor = MOTOR_HALT;
        if (r_btn_sync[0] && !r_btn_sync[1]) begin
            w_motor = MOTOR_FWD;
        end else if (r_btn_sync[1] && !r_btn_sync[0]) begin
            w_motor = MOTOR_BACK;
        end

        // Centre wins over any left/right combination.
        w_servo = SERVO_NONE;
        if (r_btn_sync[4]) begin
            w_servo = SERVO_STRAIGHT;
        end else if (r_btn_sync[2] && !r_btn_sync[3]) begin
            w_servo = SERVO_LEFT;
        end else if (r_btn_sync[3] && !r_btn_sync[2]) begin
            w_servo = SERVO_RIGHT;
        end

        w_cmd            = pack_cmd(w_motor, w_servo);
        w_tick           = (r_period_cnt == c_PER_MAX);
        w_period_cnt_nxt = w_tick ? '0 : (r_period_cnt + c_PER_ONE);

        // The load cycle samples the live command and adopts its motor code,
        // so any request arriving in that same cycle is already covered.
        w_load           = r_pending && !w_busy;
        w_last_motor_nxt = w_load ? w_motor : r_last_motor;
        w_pending_nxt    = w_load ? 1'b0
                                  : (r_pending || w_tick || (w_motor != r_last_motor));
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_btn_meta   <= 5'b00000;
            r_btn_sync   <= 5'b00000;
            r_period_cnt <= '0;
            r_pending    <= 1'b0;
            r_last_motor <= MOTOR_HALT;
        end else begin
            r_btn_meta   <= w_btn_raw;
            r_btn_sync   <= r_btn_meta;
            r_period_cnt <= w_period_cnt_nxt;
            r_pending    <= w_pending_nxt;
            r_last_motor <= w_last_motor_nxt;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_core (
        .clk         (sys_clk),
        .rst         (rst),
        .i_start     (w_load),
        .i_data      (w_cmd),
        .o_tx        (tx_pin),
        .o_busy      (w_busy),
        .o_done      (sent),
        .o_sent_byte (sent_byte)
    );

    assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_cmd_tx
//  Description : Scoreboard bench for motor_cmd_tx. A frame-level reference
//                model queues (start cycle, byte) for every frame the design
//                should send; a line monitor decodes tx_pin and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_cmd_tx;

    localparam int SYS_CLK_FREQ = 1_000_000;
    localparam int BAUD_RATE    = 100_000;
    localparam int CPB          = SYS_CLK_FREQ / BAUD_RATE;   // 10
    localparam int PER          = 600;
    localparam int FRAME        = 10 * CPB;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       btn_fwd = 1'b0, btn_back = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_center = 1'b0;
    logic       tx_pin, busy, sent;
    logic [7:0] sent_byte;

    motor_cmd_tx #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE),
        .PERIOD_CYC   (PER)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .btn_fwd    (btn_fwd),
        .btn_back   (btn_back),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .tx_pin     (tx_pin),
        .busy       (busy),
        .sent       (sent),
        .sent_byte  (sent_byte)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    logic [4:0] hist [2];     // button samples 1 and 2 cycles old
    int   m_cnt    = 0;
    logic m_pend   = 1'b0;
    int   m_last   = 0;
    int   m_free_at = 0;

    function automatic int motor_of(input logic [4:0] b);
        if (b[0] == b[1]) return 0;
        return b[0] ? 3 : 6;
    endfunction

    function automatic int servo_of(input logic [4:0] b);
        if (b[4]) return 5;
        if (b[2] == b[3]) return 0;
        return b[2] ? 3 : 6;
    endfunction

    always @(posedge sys_clk) begin
        int   mo, se;
        logic tick;
        exp_t e;
        cyc++;
        if (rst) begin
            hist[0] = '0; hist[1] = '0;
            m_cnt = 0; m_pend = 1'b0; m_last = 0; m_free_at = 0;
            exp_q.delete();
        end else begin
            mo   = motor_of(hist[1]);
            se   = servo_of(hist[1]);
            tick = (m_cnt == PER - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            if (m_pend && cyc > m_free_at) begin
                e.cyc = cyc;
                e.b   = 8'(mo * 32 + se * 4);
                exp_q.push_back(e);
                m_last    = mo;
                m_pend    = 1'b0;
                m_free_at = cyc + FRAME;
            end else if (tick || mo != m_last) begin
                m_pend = 1'b1;
            end
            hist[1] = hist[0];
            hist[0] = {btn_center, btn_right, btn_left, btn_back, btn_fwd};
        end
    end

    // ---------------- line monitor / scoreboard ----------------
    logic       mon_act = 1'b0;
    int         mon_start = 0, mon_last_start = 0;
    int         mon_frames = 0, mon_done = 0;
    logic [9:0] mon_bits;
    logic [7:0] mon_exp_byte, mon_last_byte = 8'h00;
    logic       mon_have_exp = 1'b0;

    always @(negedge sys_clk) begin
        int   off;
        exp_t e;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (sent) chk("sent_outside_frame", 1, 0);
            if (tx_pin == 1'b0) begin
                mon_act   = 1'b1;
                mon_start = cyc;
                mon_bits  = '0;
                chk("busy_at_start", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    mon_have_exp = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_start_cycle", mon_start, e.cyc);
                    mon_exp_byte = e.b;
                    mon_have_exp = 1'b1;
                end
                mon_last_start = mon_start;
                mon_frames++;
            end
        end else begin
            off = cyc - mon_start;
            if (off < FRAME && (off % CPB) == CPB / 2)
                mon_bits[4'(off / CPB)] = tx_pin;
            if (off < FRAME && sent) chk("sent_early", 1, 0);
            if (off == FRAME / 2) chk("busy_mid_frame", int'(busy), 1);
            if (off == FRAME) begin
                chk("start_bit", int'(mon_bits[0]), 0);
                chk("stop_bit", int'(mon_bits[9]), 1);
                if (mon_have_exp) begin
                    chk("line_byte", int'(mon_bits[8:1]), int'(mon_exp_byte));
                    chk("sent_byte", int'(sent_byte), int'(mon_exp_byte));
                end
                chk("sent_pulse", int'(sent), 1);
                chk("busy_after_stop", int'(busy), 0);
                mon_last_byte = mon_bits[8:1];
                mon_done++;
                mon_act = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_starts(input int n, input string nm);
        int k = 0;
        while (mon_frames < n && k < 3000) begin @(negedge sys_clk); k++; end
        if (mon_frames < n) chk({nm, "_start_timeout"}, mon_frames, n);
    endtask

    task automatic wait_dones(input int n, input string nm);
        int k = 0;
        while (mon_done < n && k < 3000) begin @(negedge sys_clk); k++; end
        if (mon_done < n) chk({nm, "_done_timeout"}, mon_done, n);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_center, btn_right, btn_left, btn_back, btn_fwd} = b;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, t, n0, d0, s60, first_byte;
        int hold;

        repeat (3) @(negedge sys_clk);
        chk("reset_tx_pin", int'(tx_pin), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sent", int'(sent), 0);
        chk("reset_sent_byte", int'(sent_byte), 0);

        // Idle after reset: first frame is the period wrap, byte 0x00.
        rst  = 1'b0;
        base = cyc;
        wait_dones(1, "first");
        chk("first_frame_offset", mon_last_start - base, PER + 1);
        chk("first_frame_byte", int'(mon_last_byte), 8'h00);

        // Forward press: 2 sync + detect + load.
        @(negedge sys_clk);
        btn_fwd = 1'b1;
        t  = cyc;
        n0 = mon_frames;
        wait_starts(n0 + 1, "fwd");
        chk("fwd_latency", mon_last_start - t, 4);
        wait_dones(mon_done + 1, "fwd");
        chk("fwd_byte", int'(mon_last_byte), 8'h60);

        // Fwd + left held: only periodic frames of 0x6C.
        @(negedge sys_clk);
        btn_left = 1'b1;
        n0 = mon_frames;
        wait_starts(n0 + 1, "left");
        wait_until(mon_last_start + 2 * PER + PER / 2);
        chk("periodic_frame_count", mon_frames - n0, 3);
        chk("periodic_byte", int'(mon_last_byte), 8'h6C);

        // Fwd + back cancel to halt.
        @(negedge sys_clk);
        btn_left = 1'b0;
        btn_back = 1'b1;
        d0 = mon_done;
        wait_dones(d0 + 1, "fwdback");
        chk("fwdback_byte", int'(mon_last_byte), 8'h00);

        // Centre overrides left+right.
        @(negedge sys_clk);
        btn_center = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
        d0 = mon_done;
        wait_dones(d0 + 1, "center");
        chk("center_byte", int'(mon_last_byte), 8'h14);

        // Back pressed mid-frame of a 0x60 frame.
        @(negedge sys_clk);
        set_btns(5'b00001);
        n0 = mon_frames;
        d0 = mon_done;
        wait_starts(n0 + 1, "mid60");
        s60 = mon_last_start;
        wait_until(s60 + 4 * CPB);
        btn_fwd  = 1'b0;
        btn_back = 1'b1;
        wait_dones(d0 + 1, "mid60");
        first_byte = int'(mon_last_byte);
        chk("mid_first_byte", first_byte, 8'h60);
        wait_dones(d0 + 2, "midC0");
        chk("mid_second_byte", int'(mon_last_byte), 8'hC0);
        chk("back_to_back_gap", mon_last_start - s60, FRAME + 1);
        wait_until(s60 + 400);
        chk("mid_extra_frames", mon_frames - n0, 2);

        // Reset during DATA bit 3.
        @(negedge sys_clk);
        btn_back = 1'b0;
        n0 = mon_frames;
        wait_starts(n0 + 1, "rstframe");
        wait_until(mon_last_start + 4 * CPB + 3);
        @(posedge sys_clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx_pin", int'(tx_pin), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(negedge sys_clk);
        rst  = 1'b0;
        base = cyc;
        n0   = mon_frames;
        wait_dones(mon_done + 1, "after_rst");
        chk("after_rst_frames", mon_frames - n0, 1);
        chk("after_rst_offset", mon_last_start - base, PER + 1);
        chk("after_rst_byte", int'(mon_last_byte), 8'h00);

        // Random button activity, including very short glitches.
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            set_btns(5'($urandom));
            hold = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1)
                                               : $urandom_range(400, 20);
            repeat (hold) @(negedge sys_clk);
        end

        // Drain.
        @(negedge sys_clk);
        set_btns(5'b00000);
        repeat (250) @(negedge sys_clk);
        for (int k = 0; k < 300 && (mon_act || exp_q.size() != 0); k++)
            @(negedge sys_clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
